// File: rtl/hamming_128_encoder.sv
// Registered Hamming(7,4) encoder: 128-bit word -> 32 packed 7-bit codewords (224 bits).
// Optional error injection on the registered word when HAMMING_ERR_INJECT_EN is defined.
module hamming_128_encoder (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [127:0] data_in,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic         inj_en,
  input  logic [7:0]   inj_pos,
`endif
  output logic [223:0] encoded_data,
  output logic         encoded_valid
);

  logic [223:0] code_word;
  logic [223:0] flip_mask;

  // Each slice emits c[6:0] = {d3, d2, d1, p4, d0, p2, p1}, i.e. classic positions 7..1.
  always_comb begin
    code_word = '0;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] d;
      d = data_in[4*i +: 4];
      code_word[7*i +: 7] = {d[3], d[2], d[1],
                             d[1] ^ d[2] ^ d[3],
                             d[0],
                             d[0] ^ d[2] ^ d[3],
                             d[0] ^ d[1] ^ d[3]};
    end
  end

`ifdef HAMMING_ERR_INJECT_EN
  // Positions 224..255 match no bit, so out-of-range requests flip nothing.
  always_comb begin
    flip_mask = '0;
    for (int j = 0; j < 224; j++) begin
      flip_mask[j] = inj_en && (inj_pos == 8'(j));
    end
  end
`else
  assign flip_mask = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encoded_data  <= '0;
      encoded_valid <= 1'b0;
    end else begin
      encoded_valid <= enable;
      if (enable) begin
        encoded_data <= code_word ^ flip_mask;
      end
    end
  end

endmodule

// File: tb/tb_hamming_128_encoder.sv
// Self-checking bench for hamming_128_encoder: positional Hamming model, random and directed stimulus.
// Error-injection checks are built when HAMMING_ERR_INJECT_EN is defined.
module tb_hamming_128_encoder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [127:0] data_in = '0;
  logic [223:0] encoded_data;
  logic         encoded_valid;
`ifdef HAMMING_ERR_INJECT_EN
  logic         inj_en = 1'b0;
  logic [7:0]   inj_pos = '0;
`endif

  hamming_128_encoder dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .data_in(data_in),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_en(inj_en),
    .inj_pos(inj_pos),
`endif
    .encoded_data(encoded_data),
    .encoded_valid(encoded_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [223:0] exp_data = '0;
  logic         exp_valid = 1'b0;
  bit           chk_en = 1'b0;

  // Classic Hamming: data at positions 3,5,6,7; parity at 2^k covers every position with bit k set.
  function automatic logic [6:0] ham(input logic [3:0] d);
    logic [7:1] pos;
    int dp[4] = '{3, 5, 6, 7};
    pos = '0;
    for (int k = 0; k < 4; k++) pos[dp[k]] = d[k];
    for (int p = 0; p < 3; p++) begin
      logic par;
      par = 1'b0;
      for (int q = 3; q <= 7; q++) if (((q >> p) & 1) == 1) par ^= pos[q];
      pos[1 << p] = par;
    end
    return pos[7:1];
  endfunction

  function automatic logic [223:0] enc(input logic [127:0] d);
    logic [223:0] r;
    for (int i = 0; i < 32; i++) r[7*i +: 7] = ham(d[4*i +: 4]);
    return r;
  endfunction

  function automatic int syndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int b = 0; b < 7; b++) if (c[b]) s ^= (b + 1);
    return s;
  endfunction

  task automatic check224(input string name, input logic [223:0] act, input logic [223:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check224("cycle_data", encoded_data, exp_data);
      check_int("cycle_valid", int'(encoded_valid), int'(exp_valid));
    end
  end

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input logic en, input logic [127:0] d, input logic ie, input logic [7:0] ip);
    enable  = en;
    data_in = d;
`ifdef HAMMING_ERR_INJECT_EN
    inj_en  = ie;
    inj_pos = ip;
`endif
    @(posedge clk);
    if (rst) begin
      exp_data  = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = en;
      if (en) begin
        exp_data = enc(d);
`ifdef HAMMING_ERR_INJECT_EN
        if (ie && ip < 8'd224) exp_data[ip] = ~exp_data[ip];
`endif
      end
    end
    #1;
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] r;
    logic [223:0] all55;
    int bad;
    ones  = '1;
    all55 = {32{7'h2D}};

    // Model pins against hand-derived codewords.
    check_int("model_h5", int'(ham(4'h5)), int'(7'h2D));
    check_int("model_hB", int'(ham(4'hB)), int'(7'b1010101));
    check_int("model_h1", int'(ham(4'h1)), int'(7'h07));

    // Asynchronous reset with enable high and all-ones data, before any clock edge.
    enable = 1'b1;
    data_in = ones;
    #1 rst = 1'b1;
    #1;
    check224("rst_async_data", encoded_data, '0);
    check_int("rst_async_valid", int'(encoded_valid), 0);
    chk_en = 1'b1;
    step(1'b1, ones, 1'b0, 8'd0);
    step(1'b1, ones, 1'b0, 8'd0);
    rst = 1'b0;
    step(1'b1, 128'h1, 1'b0, 8'd0);
    check224("lit_one", encoded_data, 224'h7);
    check_int("post_rst_valid", int'(encoded_valid), 1);

    step(1'b1, {32{4'h5}}, 1'b0, 8'd0);
    check224("lit_55", encoded_data, all55);
    step(1'b1, '0, 1'b0, 8'd0);
    check224("lit_zero", encoded_data, '0);
    step(1'b1, ones, 1'b0, 8'd0);
    check224("lit_ones", encoded_data, '1);

    // Hold: enable low, data changes must not reach the outputs.
    step(1'b1, {32{4'h5}}, 1'b0, 8'd0);
    step(1'b0, ones, 1'b0, 8'd0);
    check224("hold_data", encoded_data, all55);
    check_int("hold_valid", int'(encoded_valid), 0);
    step(1'b0, '0, 1'b0, 8'd0);
    check224("hold_data2", encoded_data, all55);

    // Sweep the top nibble and verify each group decodes cleanly.
    for (int v = 0; v < 16; v++) begin
      r = '0;
      r[127:124] = 4'(v);
      step(1'b1, r, 1'b0, 8'd0);
      check_int("slice_top", int'(encoded_data[223:217]), int'(ham(4'(v))));
      bad = 0;
      for (int g = 0; g < 32; g++) if (syndrome(encoded_data[7*g +: 7]) != 0) bad++;
      check_int("slice_syndrome", bad, 0);
    end
    check224("lit_hF_top", encoded_data, {7'h7F, 217'h0});

    // Mid-stream reset clears immediately; first valid word after release follows an enable edge.
    step(1'b1, {4{$urandom}}, 1'b0, 8'd0);
    #2 rst = 1'b1;
    #1;
    check224("midrst_data", encoded_data, '0);
    check_int("midrst_valid", int'(encoded_valid), 0);
    exp_data = '0;
    exp_valid = 1'b0;
    step(1'b1, ones, 1'b0, 8'd0);
    rst = 1'b0;
    step(1'b0, ones, 1'b0, 8'd0);
    check_int("midrst_noen_valid", int'(encoded_valid), 0);
    step(1'b1, 128'h1, 1'b0, 8'd0);
    check224("midrst_first", encoded_data, 224'h7);

`ifdef HAMMING_ERR_INJECT_EN
    step(1'b1, '0, 1'b1, 8'd223);
    check224("inj_223", encoded_data, {1'b1, 223'h0});
    step(1'b1, '0, 1'b1, 8'd224);
    check224("inj_224", encoded_data, '0);
    step(1'b1, '0, 1'b1, 8'd0);
    check224("inj_0", encoded_data, 224'h1);
    step(1'b0, ones, 1'b1, 8'd5);
    check224("inj_noen", encoded_data, 224'h1);
`endif

    // Random traffic: mixed enable, data and (when built) injection requests.
    for (int n = 0; n < 400; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
